// File: rtl/uart_pkg.sv
// Shared UART definitions: default payload width and the receive frame layout
// as stored by rx_buffer ({par_err, stop_err, data}).
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef struct packed {
        logic                   par_err;
        logic                   stop_err;
        logic [UART_DATA_W-1:0] data;
    } uart_frame_t;

endpackage

// File: rtl/rx_buffer_mem.sv
// Frame storage for rx_buffer: one synchronous write port, one asynchronous
// (show-ahead) read port. Contents are never reset.
module rx_buffer_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_buffer.sv
// UART receive FIFO with per-byte error tags, sticky overrun and drop counter.
// Define RX_BUFFER_ERR_DROP_EN to discard errored frames instead of storing them.
module rx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_stop_err,
    input  logic                     wr_par_err,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_stop_err,
    output logic                     rd_par_err,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     ovr_clr,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned MW = DATA_W + 2;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          empty_c, full_c, frame_err_c;
    logic          push_c, pop_c, ovr_set_c;
    logic [MW-1:0] rd_word_c;

    // Push/pop decisions, pointer/occupancy update and status flags
    always_comb begin
        empty_c     = (count_q == '0);
        full_c      = (count_q == CW'(DEPTH));
`ifdef RX_BUFFER_ERR_DROP_EN
        frame_err_c = wr_stop_err | wr_par_err;
`else
        frame_err_c = 1'b0;
`endif
        pop_c       = rd_en & ~empty_c;
        // A pop in the same cycle frees the slot, so a full buffer still accepts
        push_c      = wr_valid & ~frame_err_c & (~full_c | rd_en);
        ovr_set_c   = wr_valid & ~frame_err_c & full_c & ~rd_en;

        wr_ptr_d    = push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CW'(1);
        end

        // Set wins over a coincident clear
        overrun_d = overrun_q;
        if (ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (ovr_set_c) begin
            overrun_d = 1'b1;
        end

`ifdef RX_BUFFER_ERR_DROP_EN
        drop_cnt_d = drop_cnt_q;
        if (wr_valid && frame_err_c && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
`else
        drop_cnt_d = 8'd0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    rx_buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (MW)
    ) u_mem (
        .clk   (clk),
        .we    (push_c & ~reset),
        .waddr (wr_ptr_q),
        .wdata ({wr_par_err, wr_stop_err, wr_data}),
        .raddr (rd_ptr_q),
        .rdata (rd_word_c)
    );

    assign rd_data     = rd_word_c[DATA_W-1:0];
    assign rd_stop_err = rd_word_c[DATA_W];
    assign rd_par_err  = rd_word_c[DATA_W+1];
    assign empty       = empty_c;
    assign full        = full_c;
    assign count       = count_q;
    assign overrun     = overrun_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_rx_buffer.sv
// Scoreboard bench for rx_buffer: directed scenarios then randomized traffic,
// checked against a queue-based reference model.
module tb_rx_buffer;

    localparam int DEPTH = 16;
`ifdef RX_BUFFER_ERR_DROP_EN
    localparam bit ERR_DROP = 1'b1;
`else
    localparam bit ERR_DROP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_stop_err;
    logic       wr_par_err;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_stop_err;
    logic       rd_par_err;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       ovr_clr;
    logic [7:0] drop_cnt;

    rx_buffer #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_stop_err (wr_stop_err),
        .wr_par_err  (wr_par_err),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_stop_err (rd_stop_err),
        .rd_par_err  (rd_par_err),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .ovr_clr     (ovr_clr),
        .drop_cnt    (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of stored frames {par, stop, data}
    logic [9:0] mq[$];
    logic [9:0] exp_q[$];
    bit         m_ovr  = 1'b0;
    int         m_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted pop must return the next frame the model expects
    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'd1, 32'd0);
            end else begin
                check("pop_frame", {22'd0, rd_par_err, rd_stop_err, rd_data}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    // One clock of stimulus, model update and status check
    task automatic cycle(input logic rst, input logic wv, input logic [7:0] wd,
                         input logic se, input logic pe, input logic re, input logic oc);
        bit pop;
        bit ovr_set;
        ovr_set     = 1'b0;
        reset       = rst;
        wr_valid    = wv;
        wr_data     = wd;
        wr_stop_err = se;
        wr_par_err  = pe;
        rd_en       = re;
        ovr_clr     = oc;
        pop = !rst && re && (mq.size() > 0);
        if (pop) exp_q.push_back(mq[0]);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ovr  = 1'b0;
            m_drop = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (wv) begin
                if (ERR_DROP && (se || pe)) begin
                    if (m_drop < 255) m_drop++;
                end else if (mq.size() < DEPTH) begin
                    mq.push_back({pe, se, wd});
                end else begin
                    ovr_set = 1'b1;
                end
            end
            if (ovr_set) m_ovr = 1'b1;
            else if (oc) m_ovr = 1'b0;
        end
        #1;
        check("count",    32'(count),    32'(mq.size()));
        check("empty",    32'(empty),    32'(mq.size() == 0));
        check("full",     32'(full),     32'(mq.size() == DEPTH));
        check("overrun",  32'(overrun),  32'(m_ovr));
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (mq.size() > 0) begin
            check("head", {22'd0, rd_par_err, rd_stop_err, rd_data}, {22'd0, mq[0]});
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic re);
        cycle(1'b0, 1'b1, d, 1'b0, pe, re, 1'b0);
    endtask

    task automatic pop_one();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) pop_one();
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; wr_stop_err = 1'b0;
        wr_par_err = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;

        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single clean push, visible one cycle later
        push(8'hA5, 1'b0, 1'b0);
        check("a5_data", 32'(rd_data), 32'h0000_00A5);
        pop_one();

        // Fill, then drain in order across pointer wrap
        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(full), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop_one();
        check("drain_empty", 32'(empty), 32'd1);

        // Overrun while full, then clear
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), 1'b0, 1'b0);
        push(8'h55, 1'b0, 1'b0);
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_head", 32'(rd_data), 32'h0000_0010);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_clr", 32'(overrun), 32'd0);

        // Full with simultaneous push and pop; 0x77 comes out last
        push(8'h77, 1'b0, 1'b1);
        check("full_pp_count", 32'(count), 32'(DEPTH));
        drain();

        // Set and clear together: set wins
        for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_set_wins", 32'(overrun), 32'd1);
        drain();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

        // Empty with push and pop together: push only
        push(8'h99, 1'b0, 1'b1);
        check("empty_pp_count", 32'(count), 32'd1);
        drain();

        // Parity-errored frame
        push(8'h3C, 1'b1, 1'b0);
        if (ERR_DROP) check("err_drop_count", 32'(count), 32'd0);
        else          check("err_keep_par", 32'(rd_par_err), 32'd1);
        drain();

        // Reset with five entries and a frame on the input
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        idle();

        // Randomized traffic in write-heavy, read-heavy and balanced phases
        for (int i = 0; i < 3000; i++) begin
            int wpct;
            int rpct;
            wpct = (i < 1000) ? 80 : (i < 2000) ? 30 : 55;
            rpct = (i < 1000) ? 30 : (i < 2000) ? 80 : 50;
            cycle(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 99) < wpct),
                  8'($urandom),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 99) < rpct),
                  ($urandom_range(0, 19) == 0));
        end
        drain();

        @(negedge clk);
        check("exp_q_left", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_buffer.md
RX_BUFFER -- requirements
Module: rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, at least 2.
REQ-002 SHALL have parameter DATA_W, default 8, payload width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_valid, input, 1, receiver has a completed frame this cycle.
REQ-006 SHALL have port wr_data, input, DATA_W, received byte.
REQ-007 SHALL have port wr_stop_err, input, 1, stop-bit error tag for wr_data.
REQ-008 SHALL have port wr_par_err, input, 1, parity error tag for wr_data.
REQ-009 SHALL have port rd_en, input, 1, consumer pops the head entry.
REQ-010 SHALL have port rd_data, output, DATA_W, head byte (show-ahead).
REQ-011 SHALL have port rd_stop_err, output, 1, head stop tag.
REQ-012 SHALL have port rd_par_err, output, 1, head parity tag.
REQ-013 SHALL have port empty, output, 1, no entries.
REQ-014 SHALL have port full, output, 1, DEPTH entries.
REQ-015 SHALL have port count, output, clog2(DEPTH)+1, occupancy.
REQ-016 SHALL have port overrun, output, 1, sticky: a frame was lost.
REQ-017 SHALL have port ovr_clr, input, 1, clears overrun.
REQ-018 SHALL have port drop_cnt, output, 8, errored frames discarded.

Function
REQ-019 SHALL push {wr_par_err, wr_stop_err, wr_data} at the tail on a clock edge when wr_valid=1 and the buffer is not full, or is full with rd_en=1.
REQ-020 SHALL present the head entry on rd_data/rd_stop_err/rd_par_err combinationally from storage whenever empty=0; the outputs are don't-care when empty=1.
REQ-021 SHALL pop the head on a clock edge when rd_en=1 and empty=0; rd_en with empty=1 is ignored, with no underflow.
REQ-022 SHALL make a pushed entry visible at the head, with empty=0, one cycle after the write edge (write-to-read latency 1).
REQ-023 SHALL hold count unchanged on a simultaneous push and pop; increment it on push only; decrement it on pop only.
REQ-024 SHALL, when full with rd_en=1 and wr_valid=1, pop and push in the same cycle; count stays DEPTH.
REQ-025 SHALL, when empty with rd_en=1 and wr_valid=1, perform the push only; count becomes 1.
REQ-026 SHALL, on wr_valid=1 while full with rd_en=0, discard the frame, keep storage intact, and set overrun the next cycle.
REQ-027 SHALL hold overrun until ovr_clr=1; if overrun set and ovr_clr coincide, set wins.
REQ-028 SHALL wrap read and write pointers modulo DEPTH; full and empty SHALL be derived from count, or from an extra pointer MSB.
REQ-029 SHALL saturate drop_cnt at 255.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, clear both pointers and count, and set empty=1, full=0, overrun=0, drop_cnt=0; storage contents are not cleared.
REQ-031 SHALL give reset priority over wr_valid, rd_en and ovr_clr in the same cycle; a frame presented during reset is lost and overrun stays 0.

Configuration
REQ-032 SHALL use macro RX_BUFFER_ERR_DROP_EN: when defined, a frame with wr_stop_err=1 or wr_par_err=1 is not pushed and drop_cnt increments; overrun is not affected by such a frame, even when full.
REQ-033 SHALL, without RX_BUFFER_ERR_DROP_EN, store errored frames with their tags per REQ-019; drop_cnt is tied to 0.

Structure
REQ-034 SHALL place the frame struct typedef (par_err, stop_err, data) and the UART_DATA_W=8 constant in shared package uart_pkg.
REQ-035 SHALL isolate storage in sub-module rx_buffer_mem: DEPTH x (DATA_W+2), one synchronous write port and one asynchronous read port; pointers, count and flags stay in rx_buffer.

Verification
REQ-036 SHALL cover: reset, then push 0xA5 with clean tags -> next cycle empty=0, count=1, rd_data=0xA5, rd_stop_err=0, rd_par_err=0.
REQ-037 SHALL cover: 16 pushes 0x00..0x0F, then 16 pops -> full=1 after the 16th push; pops return 0x00..0x0F in order; empty=1 after the last pop; pointers have wrapped.
REQ-038 SHALL cover: full, then push 0x55 with rd_en=0 -> overrun=1, the head is unchanged, count=16; ovr_clr=1 -> overrun=0 the next cycle.
REQ-039 SHALL cover: full, with rd_en=1 and a push of 0x77 in the same cycle -> count stays 16; 0x77 is read last after 15 further pops.
REQ-040 SHALL cover: push 0x3C with wr_par_err=1 -> with macro, count=0 and drop_cnt=1; without macro, head=0x3C with rd_par_err=1.
REQ-041 SHALL cover: reset asserted with count=5 and wr_valid=1 -> next cycle count=0, empty=1, overrun=0.
